// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : ARMv4 multicycle control FSM with condition check and NZCV flags
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXECR  = 4'd6;
    localparam logic [3:0] c_EXECI  = 4'd7;
    localparam logic [3:0] c_ALUWB  = 4'd8;
    localparam logic [3:0] c_BRANCH = 4'd9;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    logic [3:0] r_state;
    logic [3:0] r_flags;
    logic [3:0] w_next;
    logic [3:0] w_out_state;
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd15;
    logic [1:0] w_aluop;
    logic       w_arith;
    logic       w_condex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_unused;

    assign w_cond   = Instr[31:28];
    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[25:20];
    assign w_rd15   = (Instr[15:12] == 4'hF);
    assign w_unused = ^{Instr[19:16], Instr[11:0]};

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        case (w_funct[4:1])
            4'b0100: w_aluop = c_ALU_ADD;
            4'b0010: w_aluop = c_ALU_SUB;
            4'b0000: w_aluop = c_ALU_AND;
            4'b1100: w_aluop = c_ALU_ORR;
            default: w_aluop = c_ALU_ADD;
        endcase
    end

    // C and V only carry meaning for arithmetic ops; logical ops preserve them.
    assign w_arith = (w_aluop == c_ALU_ADD) || (w_aluop == c_ALU_SUB);

    always_comb begin
        case (w_cond)
            4'h0:    w_condex = w_z;
            4'h1:    w_condex = ~w_z;
            4'h2:    w_condex = w_c;
            4'h3:    w_condex = ~w_c;
            4'h4:    w_condex = w_n;
            4'h5:    w_condex = ~w_n;
            4'h6:    w_condex = w_v;
            4'h7:    w_condex = ~w_v;
            4'h8:    w_condex = w_c & ~w_z;
            4'h9:    w_condex = ~w_c | w_z;
            4'hA:    w_condex = (w_n == w_v);
            4'hB:    w_condex = (w_n != w_v);
            4'hC:    w_condex = ~w_z & (w_n == w_v);
            4'hD:    w_condex = w_z | (w_n != w_v);
            4'hE:    w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = c_DECODE;
            c_DECODE: begin
                if (!w_condex || (w_op == 2'b11)) begin
                    w_next = c_FETCH;
                end else if (w_op == 2'b01) begin
                    w_next = c_MEMADR;
                end else if (w_op == 2'b00) begin
                    w_next = w_funct[5] ? c_EXECI : c_EXECR;
                end else begin
                    w_next = c_BRANCH;
                end
            end
            c_MEMADR: w_next = w_funct[0] ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_next = c_MEMWB;
            c_EXECR:  w_next = c_ALUWB;
            c_EXECI:  w_next = c_ALUWB;
            default:  w_next = c_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (((r_state == c_EXECR) || (r_state == c_EXECI)) && w_funct[0]) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_arith) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // During reset the mux selects already present FETCH so the datapath settles early.
    assign w_out_state = reset ? c_FETCH : r_state;

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = c_ALU_ADD;
        case (w_out_state)
            c_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_MEMADR: ALUSrcB = 2'b01;
            c_MEMRD:  AdrSrc  = 1'b1;
            c_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = w_rd15;
            end
            c_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            c_EXECR: ALUControl = w_aluop;
            c_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_aluop;
            end
            c_ALUWB: begin
                RegWrite = 1'b1;
                PCWrite  = w_rd15;
            end
            c_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign ImmSrc = w_op;
    assign RegSrc = {(w_op == 2'b01), (w_op == 2'b10)};
    assign State  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : directed instruction stream checked against an instruction-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  State;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        r_exp_valid = 1'b0;
    logic [3:0]  r_exp_state;
    logic [15:0] r_exp_outs;
    logic [3:0]  r_mflags;
    logic [15:0] w_act_outs;

    assign w_act_outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                         ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    always @(negedge clk) begin
        if (r_exp_valid) begin
            checks++;
            if (State !== r_exp_state) begin
                errors++;
                $display("FAIL state: instr=%h got %0d expected %0d", Instr, State, r_exp_state);
            end
            checks++;
            if (w_act_outs !== r_exp_outs) begin
                errors++;
                $display("FAIL outputs: instr=%h state=%0d got %b expected %b",
                         Instr, r_exp_state, w_act_outs, r_exp_outs);
            end
        end
    end

    function automatic logic [1:0] alu_of(input logic [31:0] ins);
        case (ins[24:21])
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Output vector: PCWrite MemWrite RegWrite IRWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ImmSrc RegSrc ALUControl
    function automatic logic [15:0] model_outs(input int st_in, input logic [31:0] ins, input bit rst);
        logic pcw, mw, rw, irw, adr, asa;
        logic [1:0] rs, asb, ac, op;
        int st;
        st = rst ? 0 : st_in;
        op = ins[27:26];
        {pcw, mw, rw, irw, adr, asa} = 6'b0;
        rs = 2'b00; asb = 2'b00; ac = 2'b00;
        case (st)
            0: begin irw = 1; pcw = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
            1: begin asa = 1; asb = 2'b10; rs = 2'b10; end
            2: asb = 2'b01;
            3: adr = 1;
            4: begin rs = 2'b01; rw = 1; pcw = (ins[15:12] == 4'hF); end
            5: begin adr = 1; mw = 1; end
            6: ac = alu_of(ins);
            7: begin asb = 2'b01; ac = alu_of(ins); end
            8: begin rw = 1; pcw = (ins[15:12] == 4'hF); end
            9: begin asb = 2'b01; rs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (rst) {pcw, mw, rw, irw} = 4'b0;
        return {pcw, mw, rw, irw, adr, rs, asa, asb, op, (op == 2'b01), (op == 2'b10), ac};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle; lit holds hand-derived states (nibble per cycle).
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                             input logic [31:0] lit, input int lit_len, input int abort_at);
        int seq[$];
        logic [1:0] op;
        op = ins[27:26];
        seq = '{0, 1};
        if (cond_ok(ins[31:28], r_mflags) && op != 2'b11) begin
            case (op)
                2'b01: begin seq.push_back(2); seq.push_back(ins[20] ? 3 : 5); if (ins[20]) seq.push_back(4); end
                2'b00: begin seq.push_back(ins[25] ? 7 : 6); seq.push_back(8); end
                default: seq.push_back(9);
            endcase
        end
        Instr = ins;
        ALUFlags = af;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                r_exp_state = 4'(seq[i]);
                r_exp_outs = model_outs(seq[i], ins, 1'b1);
                @(posedge clk); #1;
                r_mflags = 4'b0000;
                r_exp_state = 4'd0;
                r_exp_outs = model_outs(0, ins, 1'b1);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            r_exp_state = 4'(seq[i]);
            r_exp_outs = model_outs(seq[i], ins, 1'b0);
            r_exp_valid = 1'b1;
            @(negedge clk); #1;
            if (i < lit_len) begin
                checks++;
                if (State !== lit[4*i +: 4]) begin
                    errors++;
                    $display("FAIL literal_state: instr=%h cycle %0d got %0d expected %0d",
                             ins, i, State, lit[4*i +: 4]);
                end
            end
            @(posedge clk); #1;
            if (seq[i] == 6 || seq[i] == 7) begin
                if (ins[20]) begin
                    r_mflags[3:2] = af[3:2];
                    if (alu_of(ins) == 2'b00 || alu_of(ins) == 2'b01) r_mflags[1:0] = af[1:0];
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        r_mflags = 4'b0000;
        @(posedge clk); #1;
        r_exp_state = 4'd0;
        r_exp_outs = model_outs(0, Instr, 1'b1);
        r_exp_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(32'hE2821005, 4'b0000, 32'h8710,  4, -1);  // ADD imm
        run_instr(32'hE5921004, 4'b0000, 32'h43210, 5, -1);  // LDR
        run_instr(32'hE5821004, 4'b0000, 32'h5210,  4, -1);  // STR
        run_instr(32'hE1812003, 4'b0000, 32'h8610,  4, -1);  // ORR reg
        run_instr(32'hE0520003, 4'b0100, 32'h8610,  4, -1);  // SUBS -> 0100
        run_instr(32'h0A000002, 4'b0000, 32'h910,   3, -1);  // BEQ taken
        run_instr(32'h1A000002, 4'b0000, 32'h10,    2, -1);  // BNE skipped
        run_instr(32'hE0520003, 4'b0011, 32'h8610,  4, -1);  // SUBS -> 0011
        run_instr(32'hE0120003, 4'b1011, 32'h8610,  4, -1);  // ANDS -> 1011
        run_instr(32'h4A000002, 4'b0000, 32'h910,   3, -1);  // BMI taken
        run_instr(32'hE0120003, 4'b0000, 32'h8610,  4, -1);  // ANDS -> 0011, C/V held
        run_instr(32'h2A000002, 4'b0000, 32'h910,   3, -1);  // BCS taken
        run_instr(32'h6A000002, 4'b0000, 32'h910,   3, -1);  // BVS taken
        run_instr(32'h3A000002, 4'b0000, 32'h10,    2, -1);  // BCC skipped
        run_instr(32'hE2821005, 4'b0100, 32'h8710,  4, -1);  // ADD no S: flags hold
        run_instr(32'h1A000002, 4'b0000, 32'h910,   3, -1);  // BNE taken
        run_instr(32'h0A000002, 4'b0000, 32'h10,    2, -1);  // BEQ skipped
        run_instr(32'h8A000002, 4'b0000, 32'h910,   3, -1);  // BHI taken
        run_instr(32'hBA000002, 4'b0000, 32'h910,   3, -1);  // BLT taken
        run_instr(32'hCA000002, 4'b0000, 32'h10,    2, -1);  // BGT skipped
        run_instr(32'hE282F005, 4'b0000, 32'h8710,  4, -1);  // ADD to R15
        run_instr(32'hEC000000, 4'b0000, 32'h10,    2, -1);  // Op=11
        run_instr(32'hF2821005, 4'b0000, 32'h10,    2, -1);  // Cond=1111
        run_instr(32'hE5921004, 4'b0000, 32'h210,   3, 3);   // LDR cut by reset in MEMRD
        run_instr(32'h0A000002, 4'b0000, 32'h10,    2, -1);  // flags cleared: BEQ skipped
        run_instr(32'hE2821005, 4'b0000, 32'h8710,  4, -1);

        r_exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
